// File: rtl/win_buf_pkg.sv
// Shared window-buffer types: pixel/word payloads, writeback FSM states, lane mask helper.
package win_buf_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

   typedef logic [PIX_W-1:0]                  pix_t;
   typedef logic [WORD_BYTES-1:0][PIX_W-1:0]  word_t;
   typedef logic [LANE_W-1:0]                 lane_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_WRITE    = 3'd2,
      ST_NEXT_ROW = 3'd3,
      ST_FINISH   = 3'd4
   } wb_state_e;

   // Mask with the low n lanes set (n in 0..WORD_BYTES)
   function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [LANE_W:0] n);
      logic [WORD_BYTES:0] m;
      m = ({{WORD_BYTES{1'b0}}, 1'b1} << n) - {{WORD_BYTES{1'b0}}, 1'b1};
      return m[WORD_BYTES-1:0];
   endfunction

endpackage

// File: rtl/win_buf_wb_addr_gen.sv
// Writeback address generator: row base, word address and col/row counters for one frame.
module win_buf_wb_addr_gen
   import win_buf_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DIM_W  = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic [DIM_W-1:0]  row_stride,
   input  logic [DIM_W-1:0]  out_width,
   input  logic [DIM_W-1:0]  out_height,
   input  logic              inc_col,
   input  logic              inc_word,
   input  logic              next_row,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              col_last_c,
   output logic              row_end_c,
   output logic              frame_end_c
);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [DIM_W-1:0]  row_q, row_d;
   logic [DIM_W-1:0]  stride_q, stride_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [ADDR_W-1:0] next_base;

   assign next_base   = row_base_q + ADDR_W'(stride_q);
   assign col_last_c  = (DIM_W'(col_q + DIM_W'(1)) == width_q);
   assign row_end_c   = (col_q == width_q);
   assign frame_end_c = (DIM_W'(row_q + DIM_W'(1)) == height_q);
   assign ram_addr    = addr_q;

   // Next-state for config latch, address and counters
   always_comb begin
      row_base_d = row_base_q;
      addr_d     = addr_q;
      col_d      = col_q;
      row_d      = row_q;
      stride_d   = stride_q;
      width_d    = width_q;
      height_d   = height_q;
      if (load) begin
         row_base_d = dest_addr;
         addr_d     = dest_addr;
         col_d      = '0;
         row_d      = '0;
         stride_d   = row_stride;
         width_d    = out_width;
         height_d   = out_height;
      end else if (next_row) begin
         row_d = DIM_W'(row_q + DIM_W'(1));
         col_d = '0;
         if (!frame_end_c) begin
            row_base_d = next_base;
            addr_d     = next_base;
         end
      end else begin
         if (inc_word) addr_d = addr_q + ADDR_W'(WORD_BYTES);
         if (inc_col)  col_d  = DIM_W'(col_q + DIM_W'(1));
      end
   end

   // Registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         row_base_q <= '0;
         addr_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
         stride_q   <= '0;
         width_q    <= '0;
         height_q   <= '0;
      end else begin
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         col_q      <= col_d;
         row_q      <= row_d;
         stride_q   <= stride_d;
         width_q    <= width_d;
         height_q   <= height_d;
      end
   end

endmodule

// File: rtl/win_buf_writeback.sv
// Window-buffer writeback: packs 8-bit output pixels into 32-bit words and writes them
// to RAM at row-strided addresses. Define WIN_BUF_WRITEBACK_BYTE_MASK_EN to add the
// ram_byte_en lane-valid output for partial row-end words.
module win_buf_writeback
   import win_buf_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DIM_W  = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic [DIM_W-1:0]  row_stride,
   input  logic [DIM_W-1:0]  out_width,
   input  logic [DIM_W-1:0]  out_height,
   input  logic              pix_valid,
   input  pix_t              pix_data,
   output logic              pix_ready,
   input  logic              ram_w_done,
   output logic              ram_w_en,
   output logic [ADDR_W-1:0] ram_addr,
   output word_t             ram_wdata,
   output logic              busy,
   output logic              done
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
   ,
   output logic [WORD_BYTES-1:0] ram_byte_en
`endif
);

   wb_state_e state_q, state_d;
   lane_t     lane_q, lane_d;
   word_t     wdata_q, wdata_d;
   logic      w_en_q, w_en_d;
   logic      busy_q, busy_d;
   logic      done_q, done_d;
   logic      ag_load, ag_inc_col, ag_inc_word, ag_next_row;
   logic      col_last, row_end, frame_end;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
   logic [WORD_BYTES-1:0] byte_en_q, byte_en_d;
`endif

   win_buf_wb_addr_gen #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_addr_gen (
      .clk         (clk),
      .n_rst       (n_rst),
      .load        (ag_load),
      .dest_addr   (dest_addr),
      .row_stride  (row_stride),
      .out_width   (out_width),
      .out_height  (out_height),
      .inc_col     (ag_inc_col),
      .inc_word    (ag_inc_word),
      .next_row    (ag_next_row),
      .ram_addr    (ram_addr),
      .col_last_c  (col_last),
      .row_end_c   (row_end),
      .frame_end_c (frame_end)
   );

   assign pix_ready = (state_q == ST_COLLECT);
   assign ram_w_en  = w_en_q;
   assign ram_wdata = wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
   assign ram_byte_en = byte_en_q;
`endif

   // FSM next-state, byte packer and address-generator controls
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      w_en_d      = w_en_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ag_load     = 1'b0;
      ag_inc_col  = 1'b0;
      ag_inc_word = 1'b0;
      ag_next_row = 1'b0;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
      byte_en_d   = byte_en_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ag_load = 1'b1;
               lane_d  = '0;
               wdata_d = '0;
               busy_d  = 1'b1;
               state_d = ((out_width == '0) || (out_height == '0)) ? ST_FINISH : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (pix_valid) begin
               wdata_d[lane_q] = pix_data;
               lane_d          = lane_t'(lane_q + lane_t'(1));
               ag_inc_col      = 1'b1;
               if ((lane_q == lane_t'(WORD_BYTES - 1)) || col_last) begin
                  w_en_d  = 1'b1;
                  state_d = ST_WRITE;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
                  byte_en_d = lane_mask((LANE_W + 1)'(lane_q) + (LANE_W + 1)'(1));
`endif
               end
            end
         end
         ST_WRITE: begin
            if (ram_w_done) begin
               w_en_d  = 1'b0;
               lane_d  = '0;
               wdata_d = '0;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
               byte_en_d = '0;
`endif
               if (row_end) begin
                  state_d = ST_NEXT_ROW;
               end else begin
                  ag_inc_word = 1'b1;
                  state_d     = ST_COLLECT;
               end
            end
         end
         ST_NEXT_ROW: begin
            ag_next_row = 1'b1;
            state_d     = frame_end ? ST_FINISH : ST_COLLECT;
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any pending write
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         lane_q  <= '0;
         wdata_q <= '0;
         w_en_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
         byte_en_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         wdata_q <= wdata_d;
         w_en_q  <= w_en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
         byte_en_q <= byte_en_d;
`endif
      end
   end

endmodule

// File: tb/tb_win_buf_writeback.sv
// Self-checking bench for win_buf_writeback: directed and randomized frames compared
// against a frame-level model of the expected RAM write sequence.
module tb_win_buf_writeback;

   logic              clk;
   logic              n_rst;
   logic              start;
   logic [31:0]       dest_addr;
   logic [15:0]       row_stride;
   logic [15:0]       out_width;
   logic [15:0]       out_height;
   logic              pix_valid;
   logic [7:0]        pix_data;
   logic              pix_ready;
   logic              ram_w_done;
   logic              ram_w_en;
   logic [31:0]       ram_addr;
   logic [3:0][7:0]   ram_wdata;
   logic              busy;
   logic              done;
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
   logic [3:0]        ram_byte_en;
`endif

   win_buf_writeback #(.ADDR_W(32), .DIM_W(16)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .dest_addr  (dest_addr),
      .row_stride (row_stride),
      .out_width  (out_width),
      .out_height (out_height),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .ram_w_done (ram_w_done),
      .ram_w_en   (ram_w_en),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .busy       (busy),
      .done       (done)
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
      ,
      .ram_byte_en(ram_byte_en)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]  pq[$];
   logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
   logic [3:0]  exp_m[$], got_m[$];
   int          last_done_t;
   int          last_done_cnt;
   int          last_busy1;
   int          last_stable_err;
   int          last_idx;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: expected write list from frame geometry and pixel stream
   task automatic build_model(input logic [31:0] d, input logic [15:0] s,
                              input int w, input int h);
      exp_a.delete(); exp_d.delete(); exp_m.delete();
      for (int r = 0; r < h; r++) begin
         for (int k = 0; 4 * k < w; k++) begin
            logic [31:0] wd;
            logic [3:0]  m;
            wd = '0;
            m  = '0;
            for (int j = 0; j < 4; j++) begin
               if (4 * k + j < w) begin
                  wd[8*j +: 8] = pq[r * w + 4 * k + j];
                  m[j] = 1'b1;
               end
            end
            exp_a.push_back(d + 32'(r) * 32'(s) + 32'(4 * k));
            exp_d.push_back(wd);
            exp_m.push_back(m);
         end
      end
   endtask

   // Drive one frame: start pulse, pixel source, RAM responder; compare against the model
   task automatic run_frame(input string name, input logic [31:0] d, input logic [15:0] s,
                            input int w, input int h, input int first_delay,
                            input int fixed_delay, input int gap, input bit restart);
      int t, idx, wcnt, cur_delay, nw, npix;
      bit in_wr, fire;
      logic [31:0] cap_a, cap_d;
      npix = w * h;
      build_model(d, s, w, h);
      got_a.delete(); got_d.delete(); got_m.delete();
      dest_addr  = d;
      row_stride = s;
      out_width  = 16'(w);
      out_height = 16'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 1; idx = 0; wcnt = 0; cur_delay = 0; nw = 0; in_wr = 1'b0;
      cap_a = '0; cap_d = '0;
      last_done_t = -1; last_done_cnt = 0; last_busy1 = 0; last_stable_err = 0;
      while (t < 3000 && !(last_done_t >= 0 && t > last_done_t + 2)) begin
         if (t == 1) last_busy1 = int'(busy);
         start = restart && (t == 3);
         if (restart && t == 3) begin
            dest_addr  = 32'hDEAD0000;
            out_width  = 16'd3;
            out_height = 16'd9;
         end
         if (done) begin
            last_done_cnt++;
            if (last_done_t < 0) begin
               last_done_t = t;
               chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
            end
         end
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
         if (!ram_w_en && ram_byte_en !== 4'h0) last_stable_err++;
`endif
         ram_w_done = 1'b0;
         if (ram_w_en) begin
            if (!in_wr) begin
               in_wr = 1'b1;
               wcnt  = 0;
               cap_a = ram_addr;
               cap_d = ram_wdata;
               if (nw == 0 && first_delay >= 0) cur_delay = first_delay;
               else if (fixed_delay >= 0)      cur_delay = fixed_delay;
               else                             cur_delay = int'($urandom_range(0, 2));
               got_a.push_back(ram_addr);
               got_d.push_back(ram_wdata);
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
               got_m.push_back(ram_byte_en);
`else
               got_m.push_back(4'hF);
`endif
               nw++;
            end else if (ram_addr !== cap_a || ram_wdata !== cap_d) begin
               last_stable_err++;
            end
            if (pix_ready) last_stable_err++;
            if (wcnt == cur_delay) begin
               ram_w_done = 1'b1;
               in_wr = 1'b0;
            end
            wcnt++;
         end else if ($urandom_range(0, 7) == 0) begin
            ram_w_done = 1'b1;
         end
         if (idx < npix) begin
            pix_valid = (gap == 0) || (int'($urandom_range(0, 99)) >= gap);
            pix_data  = pq[idx];
         end else begin
            pix_valid = 1'b0;
            pix_data  = 8'($urandom);
         end
         fire = pix_valid && pix_ready;
         @(posedge clk); #1;
         if (fire) idx++;
         t++;
      end
      pix_valid = 1'b0; ram_w_done = 1'b0; start = 1'b0;
      last_idx = idx;
      if (last_done_t < 0) chk({name, "_timeout"}, 64'd0, 64'd1);
      chk({name, "_busy_after_start"}, 64'(last_busy1), 64'd1);
      chk({name, "_done_pulses"}, 64'(last_done_cnt), 64'd1);
      chk({name, "_pix_consumed"}, 64'(idx), 64'(npix));
      chk({name, "_stable"}, 64'(last_stable_err), 64'd0);
      chk({name, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
         chk($sformatf("%s_w%0d_addr", name, i), 64'(got_a[i]), 64'(exp_a[i]));
         chk($sformatf("%s_w%0d_data", name, i), 64'(got_d[i]), 64'(exp_d[i]));
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
         chk($sformatf("%s_w%0d_mask", name, i), 64'(got_m[i]), 64'(exp_m[i]));
`endif
      end
   endtask

   task automatic seq_pix(input int n, input logic [7:0] base);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(8'(base + 8'(i)));
   endtask

   task automatic rand_pix(input int n);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(8'($urandom));
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; dest_addr = '0; row_stride = '0;
      out_width = '0; out_height = '0; pix_valid = 1'b0; pix_data = '0; ram_w_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_w_en", 64'(ram_w_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pix_ready", 64'(pix_ready), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_wdata", 64'(ram_wdata), 64'd0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      // Basic frame
      seq_pix(16, 8'h00);
      run_frame("basic", 32'h1000, 16'd8, 8, 2, -1, 1, 0, 1'b0);
      if (got_d.size() == 4) begin
         chk("basic_lit0", 64'(got_d[0]), 64'h03020100);
         chk("basic_lit3", 64'(got_d[3]), 64'h0F0E0D0C);
         chk("basic_lit3a", 64'(got_a[3]), 64'h100C);
      end

      // Partial row-end word
      seq_pix(6, 8'hA0);
      run_frame("partial", 32'h2000, 16'd8, 6, 1, -1, 1, 0, 1'b0);
      if (got_d.size() == 2) begin
         chk("partial_lit1", 64'(got_d[1]), 64'h0000A5A4);
`ifdef WIN_BUF_WRITEBACK_BYTE_MASK_EN
         chk("partial_mask0", 64'(got_m[0]), 64'hF);
         chk("partial_mask1", 64'(got_m[1]), 64'h3);
`endif
      end

      // Backpressure on the first write
      rand_pix(12);
      run_frame("bp", 32'h3000, 16'd16, 6, 2, 5, 0, 0, 1'b0);

      // Degenerate frame
      pq.delete();
      run_frame("deg", 32'h4000, 16'd4, 4, 0, -1, 0, 0, 1'b0);
      chk("deg_done_latency", 64'(last_done_t), 64'd2);

      // Start while busy is ignored
      rand_pix(15);
      run_frame("restart", 32'h5000, 16'd12, 5, 3, -1, -1, 20, 1'b1);

      // Reset during an outstanding write
      begin
         int c;
         bit hit;
         hit = 1'b0;
         dest_addr = 32'h6000; row_stride = 16'd8; out_width = 16'd8; out_height = 16'd2;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         for (c = 0; c < 50 && !hit; c++) begin
            if (ram_w_en) begin
               hit = 1'b1;
            end else begin
               pix_valid = 1'b1;
               pix_data  = 8'(c);
               @(posedge clk); #1;
            end
         end
         pix_valid = 1'b0;
         chk("rst_mid_reached_write", 64'(hit), 64'd1);
         n_rst = 1'b0;
         @(posedge clk); #1;
         n_rst = 1'b1;
         chk("rst_mid_w_en", 64'(ram_w_en), 64'd0);
         chk("rst_mid_busy", 64'(busy), 64'd0);
         chk("rst_mid_pix_ready", 64'(pix_ready), 64'd0);
         chk("rst_mid_wdata", 64'(ram_wdata), 64'd0);
      end
      rand_pix(10);
      run_frame("after_rst", 32'h7000, 16'd20, 5, 2, -1, -1, 0, 1'b0);

      // Address wrap
      rand_pix(8);
      run_frame("wrap", 32'hFFFFFFFC, 16'd8, 8, 1, -1, 0, 0, 1'b0);
      if (got_a.size() == 2) chk("wrap_lit1", 64'(got_a[1]), 64'h0);

      // Randomized frames
      for (int f = 0; f < 10; f++) begin
         int w, h;
         logic [31:0] d;
         logic [15:0] s;
         w = int'($urandom_range(1, 13));
         h = int'($urandom_range(1, 4));
         d = {$urandom_range(0, 1) == 1 ? 30'h3FFFFFF0 + 30'($urandom_range(0, 15))
                                        : 30'($urandom), 2'b00};
         s = 16'($urandom_range(0, 16383) * 4);
         rand_pix(w * h);
         run_frame($sformatf("rnd%0d", f), d, s, w, h, -1, -1, 30, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
